imm_extend_pipe: RTL and testbench

- Parametrised, pipelined immediate-extension stage for the MIPS datapath.
- Widens an IN_WIDTH immediate to OUT_WIDTH in one of four modes: zero, sign, upper (LUI) and branch-offset (sign-extend, then shift left 2).
- Carries a sideband tag, uses a valid/ready handshake with a 2-entry skid buffer so back-pressure never drops data, and supports a pipeline flush.
- Sits between instruction decode and the ID/EX register; replaces the fixed 16->32 combinational extender.

---
 rtl/imm_extend_pipe_if.sv | 27 ++
 rtl/imm_extend_pipe.sv | 146 ++++++++++++++
 tb/tb_imm_extend_pipe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bundle for the immediate-extension stage.
// The master drives the input side and consumes the output side.
interface imm_extend_pipe_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32,
   parameter int TAG_WIDTH = 5
);
   logic                 InValid;
   logic                 InReady;
   logic [1:0]           Mode;
   logic [IN_WIDTH-1:0]  Imm;
   logic [TAG_WIDTH-1:0] InTag;
   logic                 OutValid;
   logic                 OutReady;
   logic [OUT_WIDTH-1:0] OutData;
   logic [TAG_WIDTH-1:0] OutTag;

   modport master (
      output InValid, Mode, Imm, InTag, OutReady,
      input  InReady, OutValid, OutData, OutTag
   );

   modport slave (
      input  InValid, Mode, Imm, InTag, OutReady,
      output InReady, OutValid, OutData, OutTag
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with 2-entry skid buffer and flush.
// Define IMMEXT_STATS_EN to add StatCount/StatStall outputs.
module imm_extend_pipe #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32,
   parameter int TAG_WIDTH = 5
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Flush,
   imm_extend_pipe_if.slave bus
`ifdef IMMEXT_STATS_EN
   ,
   output logic [31:0] StatCount,
   output logic        StatStall
`endif
);
   localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ONE,
      S_FULL
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [OUT_WIDTH-1:0] w_sext;
   logic [OUT_WIDTH-1:0] w_ext;
   logic [OUT_WIDTH-1:0] r_main_data;
   logic [OUT_WIDTH-1:0] r_skid_data;
   logic [TAG_WIDTH-1:0] r_main_tag;
   logic [TAG_WIDTH-1:0] r_skid_tag;

   logic w_main_vld;
   logic w_skid_vld;
   logic w_in_ready;
   logic w_in_xfer;
   logic w_out_xfer;
   logic w_ld_main_in;
   logic w_ld_main_skid;
   logic w_ld_skid;

   assign w_sext = {{EXT_W{bus.Imm[IN_WIDTH-1]}}, bus.Imm};

   always_comb begin
      w_ext = '0;
      unique case (bus.Mode)
         2'b00: w_ext = {{EXT_W{1'b0}}, bus.Imm};
         2'b01: w_ext = w_sext;
         2'b10: w_ext = {bus.Imm, {EXT_W{1'b0}}};
         2'b11: w_ext = {w_sext[OUT_WIDTH-3:0], 2'b00};
         default: w_ext = '0;
      endcase
   end

   assign w_in_xfer  = bus.InValid && w_in_ready;
   assign w_out_xfer = w_main_vld && bus.OutReady;

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (Flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         unique case (r_state)
            S_EMPTY: if (w_in_xfer) w_state_nxt = S_ONE;
            S_ONE: begin
               if (w_out_xfer && !w_in_xfer)      w_state_nxt = S_EMPTY;
               else if (w_in_xfer && !w_out_xfer) w_state_nxt = S_FULL;
            end
            S_FULL: if (w_out_xfer) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Loads are suppressed on flush; the valid bits follow the state.
   always_comb begin
      w_main_vld     = (r_state != S_EMPTY);
      w_skid_vld     = (r_state == S_FULL);
      w_in_ready     = !w_skid_vld && !Rst;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (!Flush) begin
         unique case (r_state)
            S_EMPTY: w_ld_main_in = w_in_xfer;
            S_ONE: begin
               w_ld_main_in = w_in_xfer && w_out_xfer;
               w_ld_skid    = w_in_xfer && !w_out_xfer;
            end
            S_FULL: w_ld_main_skid = w_out_xfer;
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_main_data <= '0;
         r_main_tag  <= '0;
         r_skid_data <= '0;
         r_skid_tag  <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_main_data <= w_ext;
            r_main_tag  <= bus.InTag;
         end else if (w_ld_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_tag  <= r_skid_tag;
         end
         if (w_ld_skid) begin
            r_skid_data <= w_ext;
            r_skid_tag  <= bus.InTag;
         end
      end
   end

   assign bus.InReady  = w_in_ready;
   assign bus.OutValid = w_main_vld;
   assign bus.OutData  = r_main_data;
   assign bus.OutTag   = r_main_tag;

`ifdef IMMEXT_STATS_EN
   logic [31:0] r_stat_cnt;
   logic        r_stat_stall;

   always_ff @(posedge Clk) begin
      if (Rst)             r_stat_cnt <= '0;
      else if (w_out_xfer) r_stat_cnt <= r_stat_cnt + 32'd1;
   end

   always_ff @(posedge Clk) begin
      r_stat_stall <= bus.InValid && !w_in_ready;
   end

   assign StatCount = r_stat_cnt;
   assign StatStall = r_stat_stall;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe (16->32 and 8->12 instances).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_imm_extend_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) u_if ();
   imm_extend_pipe_if #(.IN_WIDTH(8), .OUT_WIDTH(12), .TAG_WIDTH(5)) u_if8 ();

`ifdef IMMEXT_STATS_EN
   logic [31:0] stat_cnt;
   logic        stat_stall;
   logic [31:0] stat_cnt8;
   logic        stat_stall8;
`endif

   imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) u_dut (
      .Clk   (clk),
      .Rst   (rst),
      .Flush (flush),
      .bus   (u_if)
`ifdef IMMEXT_STATS_EN
      ,
      .StatCount (stat_cnt),
      .StatStall (stat_stall)
`endif
   );

   imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(12), .TAG_WIDTH(5)) u_dut8 (
      .Clk   (clk),
      .Rst   (rst),
      .Flush (1'b0),
      .bus   (u_if8)
`ifdef IMMEXT_STATS_EN
      ,
      .StatCount (stat_cnt8),
      .StatStall (stat_stall8)
`endif
   );

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [1:0] m,
                                       input logic [15:0] imm);
      int s;
      int r;
      s = imm[15] ? int'(imm) - 65536 : int'(imm);
      case (m)
         2'd0:    r = int'(imm);
         2'd1:    r = s;
         2'd2:    r = int'(imm) * 65536;
         default: r = s * 4;
      endcase
      return 32'(r);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (u_if.OutValid && u_if.OutReady) begin
            if (q.size() == 0) begin
               chk("sb_spurious", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_data", u_if.OutData, e.d);
               chk("sb_tag", 32'(u_if.OutTag), 32'(e.t));
            end
         end
         if (flush) q.delete();
         else if (u_if.InValid && u_if.InReady)
            q.push_back('{d: ext(u_if.Mode, u_if.Imm), t: u_if.InTag});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [1:0] m, input logic [15:0] imm,
                      input logic [4:0] tag);
      u_if.InValid = 1'b1;
      u_if.Mode    = m;
      u_if.Imm     = imm;
      u_if.InTag   = tag;
   endtask

   logic [31:0] mode_exp [5];
   logic [1:0]  mode_m   [5];
   logic [15:0] mode_imm [5];
   logic [11:0] w8_exp   [3];

   initial begin
      mode_exp = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000,
                   32'hFFFE_0004, 32'h0000_7FFF};
      mode_m   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      mode_imm = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF};
      w8_exp   = '{12'hF85, 12'h850, 12'hE14};

      u_if.InValid  = 1'b0;
      u_if.Mode     = 2'd0;
      u_if.Imm      = '0;
      u_if.InTag    = '0;
      u_if.OutReady = 1'b1;
      u_if8.InValid  = 1'b0;
      u_if8.Mode     = 2'd0;
      u_if8.Imm      = '0;
      u_if8.InTag    = '0;
      u_if8.OutReady = 1'b1;

      step();
      step();
      @(negedge clk);
      chk("rst_ready", 32'(u_if.InReady), 32'd0);
      chk("rst_valid", 32'(u_if.OutValid), 32'd0);
      chk("rst_data", u_if.OutData, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(u_if.InReady), 32'd1);
      step();

      for (int i = 0; i < 5; i++) begin
         drv(mode_m[i], mode_imm[i], 5'(i));
         step();
         u_if.InValid = 1'b0;
         @(negedge clk);
         chk("mode_vld", 32'(u_if.OutValid), 32'd1);
         chk("mode_data", u_if.OutData, mode_exp[i]);
         step();
      end

      u_if.OutReady = 1'b0;
      drv(2'd0, 16'h0001, 5'd1);
      step();
      drv(2'd0, 16'h0002, 5'd2);
      step();
      u_if.InValid = 1'b0;
      @(negedge clk);
      chk("bp_ready", 32'(u_if.InReady), 32'd0);
      chk("bp_data", u_if.OutData, 32'd1);
      step();
      @(negedge clk);
      chk("bp_hold", u_if.OutData, 32'd1);
      step();
      u_if.OutReady = 1'b1;
      @(negedge clk);
      chk("bp_out1", u_if.OutData, 32'd1);
      step();
      @(negedge clk);
      chk("bp_out2", u_if.OutData, 32'd2);
      chk("bp_ready2", 32'(u_if.InReady), 32'd1);
      step();
      @(negedge clk);
      chk("bp_empty", 32'(u_if.OutValid), 32'd0);
      step();

      for (int i = 0; i <= 8; i++) begin
         if (i < 8) drv(2'(i % 4), 16'($urandom), 5'(i));
         else u_if.InValid = 1'b0;
         @(negedge clk);
         if (i < 8) chk("tp_ready", 32'(u_if.InReady), 32'd1);
         if (i > 0) begin
            chk("tp_vld", 32'(u_if.OutValid), 32'd1);
            chk("tp_tag", 32'(u_if.OutTag), 32'(i - 1));
         end
         step();
      end

      u_if.OutReady = 1'b0;
      drv(2'd1, 16'h1234, 5'd10);
      step();
      drv(2'd1, 16'h5678, 5'd11);
      step();
      drv(2'd1, 16'h9ABC, 5'd12);
      flush = 1'b1;
      @(negedge clk);
      chk("fl_full_ready", 32'(u_if.InReady), 32'd0);
      step();
      flush = 1'b0;
      u_if.InValid = 1'b0;
      @(negedge clk);
      chk("fl_vld", 32'(u_if.OutValid), 32'd0);
      chk("fl_ready", 32'(u_if.InReady), 32'd1);
      u_if.OutReady = 1'b1;
      step();
      step();

      u_if.OutReady = 1'b0;
      drv(2'd2, 16'h4321, 5'd13);
      step();
      drv(2'd2, 16'h1111, 5'd14);
      flush = 1'b1;
      @(negedge clk);
      chk("fl1_ready", 32'(u_if.InReady), 32'd1);
      step();
      flush = 1'b0;
      u_if.InValid = 1'b0;
      @(negedge clk);
      chk("fl1_vld", 32'(u_if.OutValid), 32'd0);
      u_if.OutReady = 1'b1;
      step();
      step();

      u_if.OutReady = 1'b0;
      drv(2'd3, 16'hABCD, 5'd20);
      step();
      drv(2'd3, 16'h0F0F, 5'd21);
      step();
      u_if.InValid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rs_ready_in", 32'(u_if.InReady), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rs_vld", 32'(u_if.OutValid), 32'd0);
      chk("rs_data", u_if.OutData, 32'd0);
      chk("rs_tag", 32'(u_if.OutTag), 32'd0);
      chk("rs_ready", 32'(u_if.InReady), 32'd1);
`ifdef IMMEXT_STATS_EN
      chk("rs_stat", stat_cnt, 32'd0);
`endif
      u_if.OutReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drv(2'd0, 16'(i + 100), 5'(i));
         step();
      end
      u_if.InValid = 1'b0;
      step();
      step();
`ifdef IMMEXT_STATS_EN
      @(negedge clk);
      chk("stat_cnt", stat_cnt, 32'd3);
`endif

      for (int i = 0; i < 3; i++) begin
         u_if8.InValid = 1'b1;
         u_if8.Mode    = 2'(i + 1);
         u_if8.Imm     = 8'h85;
         u_if8.InTag   = 5'(i);
         step();
         u_if8.InValid = 1'b0;
         @(negedge clk);
         chk("w8_vld", 32'(u_if8.OutValid), 32'd1);
         chk("w8_data", 32'(u_if8.OutData), 32'(w8_exp[i]));
         step();
      end

      step();
      @(negedge clk);
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
